fir_sample_feeder: RTL

- Upstream stage of the serial FIR; it sits directly before it.
- Accepts 12-bit samples from the source over a valid/ready handshake and buffers them in a small FIFO.
- Issues them to the serial FIR as a one-cycle enable pulse plus a held sample, at an exact cadence of one sample every TAPS clocks. The FIR's address counter and accumulator depend on that spacing.
- If the FIFO is empty when a slot comes due, it inserts a zero sample and counts an underrun, so FIR timing is never broken.

---
 rtl/fir_pkg.sv | 7 +
 rtl/fir_in_fifo.sv | 51 +++++
 rtl/fir_sample_feeder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Constants shared by the sample feeder and the serial FIR. Cadence and
// coefficient-address width come from one place so they cannot diverge.
package fir_pkg;
  localparam int DATA_W = 12;
  localparam int TAPS   = 16;
  localparam int SLOT_W = $clog2(TAPS);
endpackage

// File: rtl/fir_in_fifo.sv
// Small synchronous FIFO with first-word-fall-through head output.
// clear empties the FIFO and overrides push/pop in the same cycle.
module fir_in_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push, do_pop;

  // Guard against overflow/underflow; depth is a power of two so pointers wrap naturally.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage array; no reset needed since occupancy gates what is read.
  always_ff @(posedge clk) begin
    if (!clear && do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + LW'(do_push) - LW'(do_pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == LW'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
endmodule

// File: rtl/fir_sample_feeder.sv
// Feeds the serial FIR: buffers source samples and issues one enable strobe
// with a held sample every TAPS clocks. An empty FIFO at a due slot sends a
// zero sample and bumps a saturating underrun counter; cadence never slips.
module fir_sample_feeder #(
  parameter int DATA_W     = fir_pkg::DATA_W,
  parameter int TAPS       = fir_pkg::TAPS,
  parameter int FIFO_DEPTH = 4,
  parameter int UCNT_W     = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [DATA_W-1:0]             s_data_i,
  output logic                          enable_o,
  output logic [DATA_W-1:0]             data_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic [UCNT_W-1:0]             underrun_cnt_o
);
  import fir_pkg::*;

  localparam int CNT_W = $clog2(TAPS);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(TAPS - 1);

  typedef enum logic { IDLE, RUN } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    slot_q, slot_d;
  logic                en_q, en_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [UCNT_W-1:0]   ucnt_q, ucnt_d;

  logic                fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_clear;
  logic [DATA_W-1:0]   fifo_head;

  // No pass-through when full: ready comes from registered occupancy only.
  assign s_ready_o  = ~fifo_full & ~flush_i & ~rst_i;
  assign fifo_push  = s_valid_i & s_ready_o;
  assign fifo_clear = rst_i | flush_i;

  fir_in_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .clear (fifo_clear),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (s_data_i),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

  // Next-state, cadence and strobe decode. The slot counter is 0 in every
  // strobe cycle, so consecutive strobes are exactly TAPS clocks apart,
  // including the first one out of IDLE.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    en_d     = 1'b0;
    data_d   = data_q;
    ucnt_d   = ucnt_q;
    fifo_pop = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
      slot_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          slot_d = '0;
          if (!fifo_empty) begin
            state_d  = RUN;
            en_d     = 1'b1;
            data_d   = fifo_head;
            fifo_pop = 1'b1;
          end
        end
        RUN: begin
          if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            en_d   = 1'b1;
            if (!fifo_empty) begin
              data_d   = fifo_head;
              fifo_pop = 1'b1;
            end else begin
              data_d = '0;
              if (ucnt_q != '1) ucnt_d = ucnt_q + 1'b1;
            end
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; reset aborts any slot in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      slot_q  <= '0;
      en_q    <= 1'b0;
      data_q  <= '0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      en_q    <= en_d;
      data_q  <= data_d;
      ucnt_q  <= ucnt_d;
    end
  end

  assign enable_o       = en_q;
  assign data_o         = data_q;
  assign busy_o         = (state_q == RUN);
  assign underrun_cnt_o = ucnt_q;
endmodule
